vec_sweep_misr: RTL and testbench

Parametrised exhaustive-vector sequencer and response compactor for combinational blocks such as the 4-in/2-out exercise modules.
- Drives all 2^N_IN input combinations in ascending order, waits SETTLE cycles per vector, and captures the N_OUT-bit response.
- Folds each response into a Galois MISR and compares the final signature against an expected value.
- Sits between the stimulus side and the device under test in on-chip self-check wrappers; replaces hand-written vector lists.

---
 rtl/vec_sweep_misr.sv | 113 +++++++++++
 tb/tb_vec_sweep_misr.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_sweep_misr.sv
// Exhaustive input-vector sequencer for combinational blocks. Each sampled response is
// folded into a Galois MISR, and the final signature is compared against a golden value.
module vec_sweep_misr #(
  parameter int unsigned       N_IN   = 4,
  parameter int unsigned       N_OUT  = 2,
  parameter int unsigned       SETTLE = 1,
  parameter int unsigned       MISR_W = 16,
  parameter logic [MISR_W-1:0] POLY   = 16'hB400,
  parameter logic [MISR_W-1:0] SEED   = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              mode,
  input  logic              step,
  input  logic [MISR_W-1:0] expected_sig,
  input  logic [N_OUT-1:0]  dut_in,
  output logic [N_IN-1:0]   vec_out,
  output logic              busy,
  output logic              done,
  output logic              cap_valid,
  output logic [N_IN-1:0]   cap_vec,
  output logic [N_OUT-1:0]  cap_resp,
  output logic [MISR_W-1:0] signature,
  output logic              pass
);

  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SETTLE - 1);
  localparam logic [N_IN-1:0] VecLast = '1;

  typedef enum logic [1:0] {StIdle, StWait, StHold, StDone} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              mode_q;
  logic [MISR_W-1:0] sig_next;

  assign sig_next = {signature[MISR_W-2:0], 1'b0}
                  ^ (signature[MISR_W-1] ? POLY : '0)
                  ^ MISR_W'(dut_in);

  assign pass = done && (signature == expected_sig);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      vec_out   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cap_valid <= 1'b0;
      cap_vec   <= '0;
      cap_resp  <= '0;
      signature <= SEED;
    end else begin
      cap_valid <= 1'b0;
      // abort leaves the signature untouched so a partial result stays inspectable
      if (abort) begin
        state_q <= StIdle;
        vec_out <= '0;
        busy    <= 1'b0;
        done    <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle, StDone: begin
            if (start) begin
              state_q   <= StWait;
              vec_out   <= '0;
              signature <= SEED;
              cnt_q     <= '0;
              mode_q    <= mode;
              busy      <= 1'b1;
              done      <= 1'b0;
            end
          end
          StWait: begin
            if (cnt_q == CntLast) begin
              cap_vec   <= vec_out;
              cap_resp  <= dut_in;
              cap_valid <= 1'b1;
              signature <= sig_next;
              // the terminal vector ends the sweep, so the vector counter never wraps
              if (vec_out == VecLast) begin
                state_q <= StDone;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else if (mode_q) begin
                state_q <= StHold;
              end else begin
                vec_out <= vec_out + 1'b1;
                cnt_q   <= '0;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StHold: begin
            if (step) begin
              vec_out <= vec_out + 1'b1;
              cnt_q   <= '0;
              state_q <= StWait;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vec_sweep_misr.sv
// Self-checking bench for vec_sweep_misr: one instance with SETTLE=1/SEED=0 and one with
// SETTLE=3/SEED=FFFF, checked against a table of known signatures and a behavioural model.
module tb_vec_sweep_misr;
  localparam logic [15:0] POLY = 16'hB400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start_a, start_b, abort, mode, step;
  logic [15:0] expected_sig;
  logic [1:0]  tab_a [16];
  logic [1:0]  tab_b [16];
  logic [1:0]  dut_in_a, dut_in_b;

  logic [3:0]  vec_out_a, vec_out_b, cap_vec_a, cap_vec_b;
  logic [1:0]  cap_resp_a, cap_resp_b;
  logic [15:0] signature_a, signature_b;
  logic        busy_a, busy_b, done_a, done_b, cap_valid_a, cap_valid_b, pass_a, pass_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Device-under-test stand-ins: pure lookup tables indexed by the driven vector
  assign dut_in_a = tab_a[vec_out_a];
  assign dut_in_b = tab_b[vec_out_b];

  vec_sweep_misr #(.N_IN(4), .N_OUT(2), .SETTLE(1), .MISR_W(16), .POLY(16'hB400),
                   .SEED(16'h0000)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort), .mode(mode), .step(step),
    .expected_sig(expected_sig), .dut_in(dut_in_a), .vec_out(vec_out_a), .busy(busy_a),
    .done(done_a), .cap_valid(cap_valid_a), .cap_vec(cap_vec_a), .cap_resp(cap_resp_a),
    .signature(signature_a), .pass(pass_a)
  );

  vec_sweep_misr #(.N_IN(4), .N_OUT(2), .SETTLE(3), .MISR_W(16), .POLY(16'hB400),
                   .SEED(16'hFFFF)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort), .mode(mode), .step(step),
    .expected_sig(expected_sig), .dut_in(dut_in_b), .vec_out(vec_out_b), .busy(busy_b),
    .done(done_b), .cap_valid(cap_valid_b), .cap_vec(cap_vec_b), .cap_resp(cap_resp_b),
    .signature(signature_b), .pass(pass_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Signature as polynomial arithmetic: multiply by x, reduce on overflow, add response
  function automatic logic [15:0] model_sig(input int sel, input logic [15:0] seed);
    int unsigned s = 32'(seed);
    for (int v = 0; v < 16; v++) begin
      s = s * 2;
      if (s >= 32'h10000) s = (s - 32'h10000) ^ 32'(POLY);
      s = s ^ 32'((sel != 0) ? tab_b[v] : tab_a[v]);
    end
    return s[15:0];
  endfunction

  // Free-run sweep on instance sel; called and returns at a falling edge
  task automatic sweep(input int sel, input logic [15:0] exp_signature,
                       input logic [15:0] golden, input logic exp_pass);
    int settle;
    int cyc;
    int n;
    settle = (sel != 0) ? 3 : 1;
    expected_sig = golden;
    mode = 1'b0;
    if (sel != 0) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    chk("start_busy", 32'((sel != 0) ? busy_b : busy_a), 1);
    chk("start_done", 32'((sel != 0) ? done_b : done_a), 0);
    cyc = 0;
    n = 0;
    while (!((sel != 0) ? done_b : done_a) && cyc < 64 * settle) begin
      @(negedge clk);
      cyc++;
      chk("vec_out", 32'((sel != 0) ? vec_out_b : vec_out_a),
          (cyc / settle > 15) ? 15 : cyc / settle);
      chk("cap_pulse", 32'((sel != 0) ? cap_valid_b : cap_valid_a), 32'((cyc % settle) == 0));
      if ((sel != 0) ? cap_valid_b : cap_valid_a) begin
        chk("cap_vec", 32'((sel != 0) ? cap_vec_b : cap_vec_a), n);
        chk("cap_resp", 32'((sel != 0) ? cap_resp_b : cap_resp_a),
            (n < 16) ? 32'((sel != 0) ? tab_b[n] : tab_a[n]) : 32'hFFFF);
        n++;
      end
    end
    chk("done_latency", cyc, 16 * settle);
    chk("cap_count", n, 16);
    chk("end_busy", 32'((sel != 0) ? busy_b : busy_a), 0);
    chk("end_done", 32'((sel != 0) ? done_b : done_a), 1);
    chk("signature", 32'((sel != 0) ? signature_b : signature_a), 32'(exp_signature));
    chk("pass", 32'((sel != 0) ? pass_b : pass_a), 32'(exp_pass));
  endtask

  typedef struct {
    logic [31:0] resp;     // 2 bits per vector, vector v at [2v+1:2v]
    logic [15:0] golden;
    logic [15:0] sig;
    logic        pass;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tv [4];
    logic [15:0] want;
    logic [15:0] sig_hold;
    logic [3:0]  vv;
    int          flip;
    int          k;

    tv[0] = '{32'h0000_0000, 16'h0000, 16'h0000, 1'b1};
    tv[1] = '{32'h0000_0000, 16'h0001, 16'h0000, 1'b0};
    tv[2] = '{32'h1000_0000, 16'h0002, 16'h0002, 1'b1};
    tv[3] = '{32'h4000_0000, 16'h0001, 16'h0001, 1'b1};

    start_a = 0; start_b = 0; abort = 0; mode = 0; step = 0; expected_sig = 0;
    for (int v = 0; v < 16; v++) begin
      tab_a[v] = 2'b00;
      tab_b[v] = 2'b00;
    end

    #1 rst_n = 1'b0;
    #1;
    chk("rst_vec", vec_out_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_cap_valid", cap_valid_a, 0);
    chk("rst_sig_a", signature_a, 16'h0000);
    chk("rst_sig_b", signature_b, 16'hFFFF);
    chk("rst_pass", pass_b, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Known-answer sweeps, back to back so each restart is issued from DONE
    for (int i = 0; i < 4; i++) begin
      for (int v = 0; v < 16; v++) tab_a[v] = tv[i].resp[2*v +: 2];
      sweep(0, tv[i].sig, tv[i].golden, tv[i].pass);
    end

    // SETTLE=3 against the E=A^B, F=C&D exercise block
    for (int v = 0; v < 16; v++) begin
      vv = 4'(v);
      tab_b[v] = {vv[3] & vv[2], vv[1] ^ vv[0]};
    end
    want = model_sig(1, 16'hFFFF);
    sweep(1, want, want, 1'b1);

    // Random response tables against the model
    for (int r = 0; r < 4; r++) begin
      for (int v = 0; v < 16; v++) begin
        tab_a[v] = 2'($urandom_range(0, 3));
        tab_b[v] = 2'($urandom_range(0, 3));
      end
      flip = $urandom_range(0, 1);
      want = model_sig(0, 16'h0000);
      sweep(0, want, want ^ 16'(flip), (flip == 0));
      want = model_sig(1, 16'hFFFF);
      sweep(1, want, want ^ 16'(1 - flip), (flip == 1));
    end

    // Single-step: a mode change after the start edge must not matter
    mode = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    mode = 1'b0;
    @(negedge clk);
    chk("ss_cap_valid0", cap_valid_a, 1);
    chk("ss_cap_vec0", cap_vec_a, 0);
    repeat (10) begin
      @(negedge clk);
      chk("ss_hold_vec", vec_out_a, 0);
      chk("ss_hold_busy", busy_a, 1);
      chk("ss_hold_cap", cap_valid_a, 0);
    end
    for (k = 1; k <= 3; k++) begin
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      chk("ss_step_vec", vec_out_a, k);
      @(negedge clk);
      chk("ss_step_cap", cap_valid_a, 1);
      chk("ss_step_cap_vec", cap_vec_a, k);
      @(negedge clk);
      chk("ss_step_hold", vec_out_a, k);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ss_abort_busy", busy_a, 0);
    chk("ss_abort_vec", vec_out_a, 0);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    @(negedge clk);
    chk("idle_step_vec", vec_out_a, 0);
    chk("idle_step_busy", busy_a, 0);
    chk("idle_step_cap", cap_valid_a, 0);

    // Abort at vector 7, with a simultaneous start that must lose
    for (int v = 0; v < 16; v++) tab_a[v] = 2'($urandom_range(0, 3));
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    k = 0;
    while (vec_out_a != 4'd7 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("abort_reach7", vec_out_a, 7);
    sig_hold = signature_a;
    abort = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start_a = 1'b0;
    chk("abort_busy", busy_a, 0);
    chk("abort_done", done_a, 0);
    chk("abort_vec", vec_out_a, 0);
    chk("abort_cap", cap_valid_a, 0);
    chk("abort_sig", signature_a, 32'(sig_hold));
    @(negedge clk);
    chk("abort_stays_idle", busy_a, 0);

    // start while busy must not restart the sweep
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_start_pre", vec_out_a, 3);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("busy_start_vec", vec_out_a, 4);
    k = 0;
    while (!done_a && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("busy_start_done", done_a, 1);
    chk("busy_start_sig", signature_a, 32'(model_sig(0, 16'h0000)));

    // Asynchronous reset mid-sweep
    for (int v = 0; v < 16; v++) tab_a[v] = 2'b11;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_sig_nonzero", 32'(signature_a != 16'h0000), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_vec", vec_out_a, 0);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_done", done_a, 0);
    chk("mid_rst_cap_valid", cap_valid_a, 0);
    chk("mid_rst_cap_vec", cap_vec_a, 0);
    chk("mid_rst_cap_resp", cap_resp_a, 0);
    chk("mid_rst_sig", signature_a, 16'h0000);
    chk("mid_rst_sig_b", signature_b, 16'hFFFF);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
